// File: rtl/seg_execute_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Holds the op codes, the FSM state type and the op decode helpers.
package seg_execute_mdu_pkg;

  localparam logic [2:0] MDOP_MULT  = 3'b000;
  localparam logic [2:0] MDOP_MULTU = 3'b001;
  localparam logic [2:0] MDOP_DIV   = 3'b010;
  localparam logic [2:0] MDOP_DIVU  = 3'b011;
  localparam logic [2:0] MDOP_MTHI  = 3'b100;
  localparam logic [2:0] MDOP_MTLO  = 3'b101;
  localparam logic [2:0] MDOP_MFHI  = 3'b110;
  localparam logic [2:0] MDOP_MFLO  = 3'b111;

  // Divide-by-zero quotient is all ones; one bit here, replicated to LEN by the user.
  localparam logic DIV0_LO_BIT = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } mdu_state_t;

  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MDOP_MULT) || (op == MDOP_DIV);
  endfunction

endpackage

// File: rtl/seg_execute_fwd_mux.sv
// Generalised N-source operand forwarding mux; out-of-range selects fall back
// to source 0 (the register file).
module seg_execute_fwd_mux #(
  parameter int LEN        = 32,
  parameter int N_FWD      = 4,
  parameter int NB_FWD_SEL = 2
) (
  input  logic [NB_FWD_SEL-1:0] i_sel,
  input  logic [N_FWD*LEN-1:0]  i_data,
  output logic [LEN-1:0]        o_data
);

  always_comb begin
    o_data = i_data[0 +: LEN];
    for (int k = 1; k < N_FWD; k++) begin
      if (int'(i_sel) == k) o_data = i_data[k*LEN +: LEN];
    end
  end

endmodule

// File: rtl/seg_execute_mdu.sv
// Iterative multiply/divide unit with private HI/LO, running in the background of EX.
// Optional macro MDU_EARLY_TERM_EN: multiplies leave RUN once the remaining multiplier bits are zero.
module seg_execute_mdu
  import seg_execute_mdu_pkg::*;
#(
  parameter int LEN            = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int N_FWD          = 4,
  parameter int NB_FWD_SEL     = 2,
  parameter int NB_MDOP        = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [NB_MDOP-1:0]    i_op,
  input  logic                  i_flush,
  input  logic [NB_FWD_SEL-1:0] i_fwd_sel_a,
  input  logic [NB_FWD_SEL-1:0] i_fwd_sel_b,
  input  logic [N_FWD*LEN-1:0]  i_fwd_data,
  output logic                  o_stall,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [LEN-1:0]        o_result,
  output logic [LEN-1:0]        o_hi,
  output logic [LEN-1:0]        o_lo
);

  localparam int STEPS   = LEN / BITS_PER_CYCLE;
  localparam int NB_STEP = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [NB_STEP-1:0] LAST_STEP = NB_STEP'(STEPS - 1);

  mdu_state_t state;
  logic [LEN-1:0]     op_a, op_b, hi, lo;
  logic [LEN-1:0]     a_mag, b_mag;
  logic               a_neg, b_neg, accept, run_exit;
  logic               busy, done, is_mul, neg_lo, neg_hi;
  logic [2*LEN-1:0]   acc, aux, acc_nxt, aux_nxt, prod_fix;
  logic [LEN-1:0]     mplier, mplier_nxt, quo_fix, rem_fix;
  logic [LEN:0]       trial;
  logic [NB_STEP-1:0] step;

  seg_execute_fwd_mux #(.LEN(LEN), .N_FWD(N_FWD), .NB_FWD_SEL(NB_FWD_SEL)) u_fwd_a (
    .i_sel (i_fwd_sel_a),
    .i_data(i_fwd_data),
    .o_data(op_a)
  );

  seg_execute_fwd_mux #(.LEN(LEN), .N_FWD(N_FWD), .NB_FWD_SEL(NB_FWD_SEL)) u_fwd_b (
    .i_sel (i_fwd_sel_b),
    .i_data(i_fwd_data),
    .o_data(op_b)
  );

  assign accept = i_valid & ~busy;
  assign a_neg  = op_is_signed(i_op) & op_a[LEN-1];
  assign b_neg  = op_is_signed(i_op) & op_b[LEN-1];
  assign a_mag  = a_neg ? -op_a : op_a;
  assign b_mag  = b_neg ? -op_b : op_b;

  // One RUN cycle: BITS_PER_CYCLE shift-add multiply or restoring divide steps.
  // Divide keeps {remainder, dividend/quotient} in acc and the divisor in aux.
  always_comb begin
    acc_nxt    = acc;
    aux_nxt    = aux;
    mplier_nxt = mplier;
    trial      = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (is_mul) begin
        if (mplier_nxt[0]) acc_nxt = acc_nxt + aux_nxt;
        aux_nxt    = aux_nxt << 1;
        mplier_nxt = mplier_nxt >> 1;
      end else begin
        trial = {acc_nxt[2*LEN-1:LEN], acc_nxt[LEN-1]};
        if (trial >= {1'b0, aux_nxt[LEN-1:0]}) begin
          trial   = trial - {1'b0, aux_nxt[LEN-1:0]};
          acc_nxt = {trial[LEN-1:0], acc_nxt[LEN-2:0], 1'b1};
        end else begin
          acc_nxt = {trial[LEN-1:0], acc_nxt[LEN-2:0], 1'b0};
        end
      end
    end
  end

`ifdef MDU_EARLY_TERM_EN
  assign run_exit = (step == LAST_STEP) || (is_mul && (mplier_nxt == '0));
`else
  assign run_exit = (step == LAST_STEP);
`endif

  assign prod_fix = neg_lo ? -acc : acc;
  assign quo_fix  = neg_lo ? -acc[LEN-1:0] : acc[LEN-1:0];
  assign rem_fix  = neg_hi ? -acc[2*LEN-1:LEN] : acc[2*LEN-1:LEN];

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state  <= S_IDLE;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      aux    <= '0;
      mplier <= '0;
      step   <= '0;
      is_mul <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (i_op)
              MDOP_MTHI: hi <= op_a;
              MDOP_MTLO: lo <= op_a;
              MDOP_MFHI, MDOP_MFLO: ;
              default: begin
                busy   <= 1'b1;
                step   <= '0;
                is_mul <= op_is_mul(i_op);
                if (op_is_mul(i_op)) begin
                  acc    <= '0;
                  aux    <= {{LEN{1'b0}}, a_mag};
                  mplier <= b_mag;
                  neg_lo <= a_neg ^ b_neg;
                  neg_hi <= 1'b0;
                  state  <= S_RUN;
`ifdef MDU_EARLY_TERM_EN
                  if (b_mag == '0) state <= S_FIN;
`endif
                end else if (op_b == '0) begin
                  // Divide by zero: result is preloaded, FIN only publishes it.
                  acc    <= {op_a, {LEN{DIV0_LO_BIT}}};
                  aux    <= '0;
                  mplier <= '0;
                  neg_lo <= 1'b0;
                  neg_hi <= 1'b0;
                  state  <= S_FIN;
                end else begin
                  acc    <= {{LEN{1'b0}}, a_mag};
                  aux    <= {{LEN{1'b0}}, b_mag};
                  mplier <= '0;
                  neg_lo <= a_neg ^ b_neg;
                  neg_hi <= a_neg;
                  state  <= S_RUN;
                end
              end
            endcase
          end
        end
        S_RUN: begin
          if (i_flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            acc    <= acc_nxt;
            aux    <= aux_nxt;
            mplier <= mplier_nxt;
            step   <= step + 1'b1;
            if (run_exit) state <= S_FIN;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (!i_flush) begin
            done <= 1'b1;
            if (is_mul) begin
              hi <= prod_fix[2*LEN-1:LEN];
              lo <= prod_fix[LEN-1:0];
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_stall  = i_valid & busy;
  assign o_busy   = busy;
  assign o_done   = done;
  assign o_hi     = hi;
  assign o_lo     = lo;
  assign o_result = (i_op == MDOP_MFLO) ? lo : hi;

endmodule

// File: tb/tb_seg_execute_mdu.sv
// Self-checking bench for seg_execute_mdu: directed cases plus random mult/div
// against an arithmetic reference model; honours MDU_EARLY_TERM_EN for latency.
module tb_seg_execute_mdu;

  localparam int LEN = 32;
  localparam int N_FWD = 4;
  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                         OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101,
                         OP_MFHI = 3'b110;

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b0;
  logic               i_valid = 1'b0;
  logic [2:0]         i_op = 3'b000;
  logic               i_flush = 1'b0;
  logic [1:0]         i_fwd_sel_a = 2'd0;
  logic [1:0]         i_fwd_sel_b = 2'd0;
  logic [N_FWD*LEN-1:0] i_fwd_data = '0;
  logic               o_stall, o_busy, o_done;
  logic [LEN-1:0]     o_result, o_hi, o_lo;

  int tests_run = 0;
  int tests_failed = 0;

  seg_execute_mdu #(.LEN(LEN), .BITS_PER_CYCLE(1), .N_FWD(N_FWD), .NB_FWD_SEL(2), .NB_MDOP(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_op(i_op), .i_flush(i_flush),
    .i_fwd_sel_a(i_fwd_sel_a), .i_fwd_sel_b(i_fwd_sel_b), .i_fwd_data(i_fwd_data),
    .o_stall(o_stall), .o_busy(o_busy), .o_done(o_done), .o_result(o_result),
    .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 i_clk = ~i_clk;

  // Reference {HI,LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_hilo(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == OP_DIV) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = longint'({32'b0, a}) / longint'({32'b0, b});
          r = longint'({32'b0, a}) % longint'({32'b0, b});
        end
        qv = 64'(q);
        rv = 64'(r);
        return {rv[31:0], qv[31:0]};
      end
    endcase
  endfunction

  // Cycle (accept edge = 0) in which o_done is expected.
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b);
`ifdef MDU_EARLY_TERM_EN
    logic [31:0] mag;
    int msb;
`endif
    if ((op == OP_DIV || op == OP_DIVU) && b == 32'd0) return 2;
`ifdef MDU_EARLY_TERM_EN
    if (op == OP_MULT || op == OP_MULTU) begin
      mag = (op == OP_MULT && b[31]) ? -b : b;
      if (mag == 32'd0) return 2;
      msb = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
      return msb + 3;
    end
`endif
    return 34;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one op for exactly one edge; returns #1 into cycle 1.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] sel_a, input logic [1:0] sel_b);
    for (int k = 0; k < N_FWD; k++) i_fwd_data[k*LEN +: LEN] = $urandom;
    i_fwd_data[int'(sel_a)*LEN +: LEN] = a;
    i_fwd_data[int'(sel_b)*LEN +: LEN] = b;
    i_fwd_sel_a = sel_a;
    i_fwd_sel_b = sel_b;
    i_op = op;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (o_done !== 1'b1 && cyc < 100) begin
      @(posedge i_clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] sel_a, input logic [1:0] sel_b);
    logic [63:0] exp_hilo;
    int cyc;
    exp_hilo = ref_hilo(op, a, b);
    applyStimulus(op, a, b, sel_a, sel_b);
    checkOutput({tag, " busy@1"}, 64'(o_busy), 64'(1));
    wait_done(cyc);
    checkOutput({tag, " latency"}, 64'(cyc), 64'(ref_latency(op, b)));
    checkOutput({tag, " hilo"}, {o_hi, o_lo}, exp_hilo);
    checkOutput({tag, " busy@done"}, 64'(o_busy), 64'(0));
  endtask

  initial begin
    int cnt;
    logic saw_done;
    logic [2:0] rop;
    logic [31:0] ra, rb, flush_b;
    logic [1:0] rsa, rsb;

    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("reset busy", 64'(o_busy), 64'(0));
    checkOutput("reset done", 64'(o_done), 64'(0));
    checkOutput("reset stall", 64'(o_stall), 64'(0));
    checkOutput("reset hilo", {o_hi, o_lo}, 64'(0));
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;

    run_op("mult -3*7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 2'd0, 2'd1);
    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 2'd2, 2'd3);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 2'd2, 2'd3);
    run_op("div by 0", OP_DIV, 32'h1234_5678, 32'd0, 2'd1, 2'd0);
    run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2'd3, 2'd1);
    run_op("multu 0x1234*1", OP_MULTU, 32'h0000_1234, 32'd1, 2'd0, 2'd2);

    // MFHI issued right behind a multiply must stall until the unit frees up.
    applyStimulus(OP_MULTU, 32'd5, 32'd6, 2'd1, 2'd2);
    i_op = OP_MFHI;
    i_valid = 1'b1;
    cnt = 0;
    while (o_stall === 1'b1 && cnt < 100) begin
      cnt++;
      @(posedge i_clk);
      #1;
    end
    checkOutput("mfhi stall cycles", 64'(cnt), 64'(ref_latency(OP_MULTU, 32'd6) - 1));
    checkOutput("mfhi result", 64'(o_result), 64'(0));
    checkOutput("multu 5*6 lo", 64'(o_lo), 64'(30));
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;

    applyStimulus(OP_MTLO, 32'h0000_00AA, 32'd0, 2'd3, 2'd0);
    checkOutput("mtlo lo", 64'(o_lo), 64'h0AA);
`ifdef MDU_EARLY_TERM_EN
    flush_b = 32'h8000_0003;
`else
    flush_b = 32'd3;
`endif
    applyStimulus(OP_MULTU, 32'd3, flush_b, 2'd0, 2'd1);
    repeat (9) begin
      @(posedge i_clk);
      #1;
    end
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    checkOutput("flush busy", 64'(o_busy), 64'(0));
    saw_done = 1'b0;
    repeat (40) begin
      if (o_done === 1'b1) saw_done = 1'b1;
      @(posedge i_clk);
      #1;
    end
    checkOutput("flush no done", 64'(saw_done), 64'(0));
    checkOutput("flush lo kept", 64'(o_lo), 64'h0AA);

    applyStimulus(OP_MTHI, 32'h5555_1234, 32'd0, 2'd2, 2'd1);
    checkOutput("mthi hi", 64'(o_hi), 64'h5555_1234);
    applyStimulus(OP_MULT, 32'hDEAD_BEEF, 32'h8765_4321, 2'd1, 2'd3);
    repeat (4) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    checkOutput("midop reset hilo", {o_hi, o_lo}, 64'(0));
    checkOutput("midop reset busy", 64'(o_busy), 64'(0));
    i_rst = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      if (o_done === 1'b1) saw_done = 1'b1;
      @(posedge i_clk);
      #1;
    end
    checkOutput("midop reset no done", 64'(saw_done), 64'(0));

    for (int n = 0; n < 16; n++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      rsa = 2'($urandom_range(0, 3));
      rsb = 2'($urandom_range(0, 3));
      if (rsa == rsb) rb = ra;
      run_op($sformatf("rand%0d op%0d", n, rop), rop, ra, rb, rsa, rsb);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
